aes_key_expander: RTL and testbench
===================================

# aes_key_expander

Iterative AES key-schedule engine that sits directly upstream of the `InvCipher` core. It expands a 128/192/256-bit cipher key into all Nr+1 round keys, generating one 32-bit schedule word per clock. It buffers the words in an internal word memory and serves any 128-bit round key through a registered read port, so the inverse cipher can fetch keys in its own round order.

## Interface
- `KEY_SIZE`, default 256: key length in bits, legal values 128/192/256. Nk = KEY_SIZE/32; Nr = 10/12/14.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request expansion of `key`; sampled only in IDLE or DONE.
- `key`  in  256  cipher key, MSB-aligned: bits [255:256-KEY_SIZE] are used, the rest are ignored.
- `busy`  out  1  high while expansion is in progress.
- `ready`  out  1  high when all round keys are valid; stays high until the next accepted `start` or `reset`.
- `rd_round`  in  4  round-key index requested.
- `rd_key`  out  128  round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}, registered.

## Operation
- Clock is `clk`. Reset is synchronous, active-high, on `reset`.
- The key memory holds 4·(Nr+1) words: 44, 52 or 60 words of 32 bits.
- State machine:
  - IDLE: `start`=1 → load w[0..Nk-1] from `key` (w[0] = most significant word). Set i = Nk and rcon = 8'h01. Go to EXPAND.
  - EXPAND: each cycle writes w[i] = w[i-Nk] ^ temp, then i increments.
    - If i mod Nk = 0: temp = SubWord(RotWord(w[i-1])) ^ {rcon, 24'h0}, and rcon is updated to xtime(rcon) (reduction polynomial 0x11B).
    - If Nk = 8 and i mod 8 = 4: temp = SubWord(w[i-1]).
    - Otherwise: temp = w[i-1].
    - When the last word, i = 4·(Nr+1)-1, is written → DONE.
  - DONE: `ready`=1. `start`=1 reloads the key and goes to EXPAND, with behaviour identical to IDLE.
- SubWord uses 4 parallel forward AES S-box lookups (combinational).
- w[i-1] is held in a register, so each cycle needs only one memory read, w[i-Nk].
- `start` is ignored in EXPAND. A changing `key` during EXPAND has no effect, because the key is captured only at the accepted start.
- Read port:
  - `rd_key` is registered each cycle as the round key addressed by the (possibly remapped) `rd_round`.
  - If `ready`=0, or the effective index > Nr, `rd_key` is 0.

## Timing
- Reset values: state IDLE, `busy`=0, `ready`=0, `rd_key`=0, i=0, rcon=8'h01. The memory is not cleared.
- Start accepted at edge E0: initial words written, `busy`=1 from E0, `ready`=0 from E0.
- Generated words are written on edges E1..EG, with G = 40/46/52 for KEY_SIZE = 128/192/256.
- At EG: `busy`→0 and `ready`→1. Start-to-ready latency is G cycles.
- Read latency: `rd_round` applied before edge N gives `rd_key` valid after edge N (1 cycle). Back-to-back reads are supported, one per cycle.
- Restart from DONE: `ready` drops on the start edge. The old keys are unreadable (`rd_key`=0) until the new `ready`.
- `reset` mid-EXPAND: IDLE on the next edge, all outputs go to their reset values, and the partial schedule is discarded.
- Simultaneous `reset` and `start`: `reset` wins.

## Configuration
- `KEYEXP_INV_ORDER_EN`:
  - Defined: the effective index is Nr − `rd_round` (for `rd_round` ≤ Nr), so index 0 returns the last round key, matching InvCipher round order. `rd_round` > Nr returns 0.
  - Undefined: the effective index is `rd_round` (forward order).

## Test plan
- KEY_SIZE=256, macro undefined, key 000102…1f.
  - `ready` must rise exactly 52 cycles after the start edge.
  - rd_round=0 → 000102030405060708090a0b0c0d0e0f.
  - rd_round=1 → 101112131415161718191a1b1c1d1e1f.
  - rd_round=14 → 24fc79ccbf0979e9371ac23c6d68de36.
- KEY_SIZE=128, key 2b7e151628aed2a6abf7158809cf4f3c in [255:128].
  - Latency must be 40 cycles.
  - rd_round=10 → d014f9a8c9ee2589e13f0cc8b6630ca6.
  - rd_round=11 → 0.
- KEY_SIZE=192, key 000102…17.
  - Latency must be 46 cycles.
  - rd_round=12 → a4970a331a78dc09c418c271e3a41d5d.
- KEY_SIZE=256 with `KEYEXP_INV_ORDER_EN` defined, same key as the first scenario.
  - rd_round=0 → 24fc79ccbf0979e9371ac23c6d68de36.
  - rd_round=14 → 000102030405060708090a0b0c0d0e0f.
  - rd_round=15 → 0.
- Robustness:
  - Assert `reset` 20 cycles into EXPAND → next cycle `busy`=0, `ready`=0, `rd_key`=0.
  - Re-start → the full 52-cycle expansion again, with correct keys.
  - Pulse `start` while `busy`=1 → ignored, with no change to latency.
  - Change `key` mid-expansion → the result is unchanged.

Source files
------------

// File: rtl/aes_key_expander.sv
// aes_key_expander
//   Iterative AES key schedule. It expands a 128/192/256-bit cipher key into
//   all Nr+1 round keys, producing one 32-bit schedule word per clock. The
//   words are kept in an internal word memory, and a registered read port
//   serves any 128-bit round key.
//
//   Parameter KEY_SIZE : 128 / 192 / 256 (Nk = KEY_SIZE/32, Nr = Nk+6)
//   Optional build macro KEYEXP_INV_ORDER_EN : when defined, rd_round is
//     remapped to Nr - rd_round so index 0 returns the last round key
//     (inverse-cipher order). When it is undefined, reads use forward order.
//
//   Ports
//     clk       in   rising-edge clock
//     reset     in   synchronous, active-high reset
//     start     in   begin expansion of key (accepted in IDLE/DONE only)
//     key       in   256-bit cipher key, MSB-aligned (top KEY_SIZE bits used)
//     busy      out  expansion in progress
//     ready     out  all round keys valid
//     rd_round  in   round-key index to read
//     rd_key    out  registered round key {w[4r],w[4r+1],w[4r+2],w[4r+3]}
module aes_key_expander #(
  parameter int KEY_SIZE = 256
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [255:0] key,
  output logic         busy,
  output logic         ready,
  input  logic [3:0]   rd_round,
  output logic [127:0] rd_key
);

  localparam int NK = KEY_SIZE / 32;
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);

  localparam logic [3:0] NR4    = 4'(NR);
  localparam logic [5:0] NK6    = 6'(NK);
  localparam logic [5:0] LAST_I = 6'(NW - 1);
  localparam logic [2:0] NK_M1  = 3'(NK - 1);

  // Forward AES S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry x sits at bit 2047-8x = 8*(255-x)+7, i.e. {~x, 3'b111}.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b111} -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_DONE} state_t;

  state_t      r_state, w_next;
  logic [31:0] r_mem [0:NW-1];
  logic [5:0]  r_i;
  logic [2:0]  r_phase;   // i mod Nk, tracked incrementally
  logic [7:0]  r_rcon;
  logic [31:0] r_prev;    // w[i-1], so only w[i-Nk] comes from the memory

  logic        w_load, w_step;
  logic [5:0]  w_src_idx;
  logic [31:0] w_old, w_sub_in, w_sub, w_temp, w_new;
  logic [7:0]  w_rcon_nxt;

  // FSM next-state and control
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_step = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_load = 1'b1;
          w_next = S_EXPAND;
        end
      end
      S_EXPAND: begin
        w_step = 1'b1;
        if (r_i == LAST_I) w_next = S_DONE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign busy  = (r_state == S_EXPAND);
  assign ready = (r_state == S_DONE);

  // Schedule word datapath. A single shared SubWord serves both the
  // RotWord case (i mod Nk = 0) and the 256-bit mid-block case.
  always_comb begin
    w_src_idx  = (r_i >= NK6) ? (r_i - NK6) : 6'd0;
    w_old      = r_mem[w_src_idx];
    w_sub_in   = (r_phase == 3'd0) ? {r_prev[23:0], r_prev[31:24]} : r_prev;
    w_sub      = sub_word(w_sub_in);
    w_rcon_nxt = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
    if (r_phase == 3'd0)
      w_temp = w_sub ^ {r_rcon, 24'h0};
    else if ((NK == 8) && (r_phase == 3'd4))
      w_temp = w_sub;
    else
      w_temp = r_prev;
    w_new = w_old ^ w_temp;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_i     <= 6'd0;
      r_phase <= 3'd0;
      r_rcon  <= 8'h01;
      r_prev  <= 32'h0;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_i     <= NK6;
        r_phase <= 3'd0;
        r_rcon  <= 8'h01;
        r_prev  <= key[255-32*(NK-1) -: 32];
      end else if (w_step) begin
        r_i     <= r_i + 6'd1;
        r_phase <= (r_phase == NK_M1) ? 3'd0 : r_phase + 3'd1;
        if (r_phase == 3'd0) r_rcon <= w_rcon_nxt;
        r_prev  <= w_new;
      end
    end
  end

  // Word memory: not cleared by reset; the key is captured only at start.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (w_load) begin
        for (int k = 0; k < NK; k++) r_mem[k] <= key[255-32*k -: 32];
      end else if (w_step) begin
        r_mem[r_i] <= w_new;
      end
    end
  end

  // Read port
  logic       w_rd_ok;
  logic [3:0] w_eff;
  logic [5:0] w_base;

  always_comb begin
    w_rd_ok = (rd_round <= NR4);
`ifdef KEYEXP_INV_ORDER_EN
    w_eff   = NR4 - rd_round;
`else
    w_eff   = rd_round;
`endif
    w_base  = w_rd_ok ? {w_eff, 2'b00} : 6'd0;
  end

  // Gating on !w_load hides the old keys starting at the restart edge itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_key <= 128'h0;
    end else if ((r_state == S_DONE) && !w_load && w_rd_ok) begin
      rd_key <= {r_mem[w_base], r_mem[w_base + 6'd1],
                 r_mem[w_base + 6'd2], r_mem[w_base + 6'd3]};
    end else begin
      rd_key <= 128'h0;
    end
  end

  generate
    if (KEY_SIZE < 256) begin : g_unused_key
      logic w_unused_key_bits;
      assign w_unused_key_bits = ^key[255-KEY_SIZE:0];
    end
  endgenerate

endmodule

// File: tb/tb_aes_key_expander.sv
// Testbench for aes_key_expander: three instances (128/192/256-bit keys)
// share one clock. Reads are queued with their expected round key and a
// monitor compares them one cycle later. The expected keys are FIPS-197
// vectors.
module tb_aes_key_expander;

  logic         clk;
  logic         rst   [3];
  logic         st    [3];
  logic [255:0] k     [3];
  logic [3:0]   rr    [3];
  logic         busy_o[3];
  logic         rdy_o [3];
  logic [127:0] rdk   [3];

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  aes_key_expander #(.KEY_SIZE(128)) u128 (
    .clk(clk), .reset(rst[0]), .start(st[0]), .key(k[0]), .busy(busy_o[0]),
    .ready(rdy_o[0]), .rd_round(rr[0]), .rd_key(rdk[0]));
  aes_key_expander #(.KEY_SIZE(192)) u192 (
    .clk(clk), .reset(rst[1]), .start(st[1]), .key(k[1]), .busy(busy_o[1]),
    .ready(rdy_o[1]), .rd_round(rr[1]), .rd_key(rdk[1]));
  aes_key_expander #(.KEY_SIZE(256)) u256 (
    .clk(clk), .reset(rst[2]), .start(st[2]), .key(k[2]), .busy(busy_o[2]),
    .ready(rdy_o[2]), .rd_round(rr[2]), .rd_key(rdk[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int           d;
    logic [127:0] exp;
    string        nm;
  } sb_t;

  sb_t pend[$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reads issued before edge N are compared after edge N.
  initial begin
    sb_t infl[$];
    forever begin
      @(posedge clk);
      infl = pend;
      pend.delete();
      @(negedge clk);
      foreach (infl[j]) chk(infl[j].nm, rdk[infl[j].d], infl[j].exp);
    end
  end

  function automatic int nr_of(input int d);
    return (d == 0) ? 10 : (d == 1) ? 12 : 14;
  endfunction

  function automatic int g_of(input int d);
    return (d == 0) ? 40 : (d == 1) ? 46 : 52;
  endfunction

  // Round index addressed by rd_round; -1 means out of range (reads 0).
  function automatic int eff_of(input int d, input int r);
    if (r > nr_of(d)) return -1;
`ifdef KEYEXP_INV_ORDER_EN
    return nr_of(d) - r;
`else
    return r;
`endif
  endfunction

  // Known FIPS-197 round keys; returns 0 when no reference is tabulated.
  function automatic bit gold(input int d, input int e, output logic [127:0] v);
    v = 128'h0;
    if (e < 0) return 1'b1;
    case (d)
      0: case (e)
        0:  begin v = 128'h2b7e151628aed2a6abf7158809cf4f3c; return 1'b1; end
        1:  begin v = 128'ha0fafe1788542cb123a339392a6c7605; return 1'b1; end
        10: begin v = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6; return 1'b1; end
        default: return 1'b0;
      endcase
      1: case (e)
        0:  begin v = 128'h000102030405060708090a0b0c0d0e0f; return 1'b1; end
        1:  begin v = 128'h10111213141516175846f2f95c43f4fe; return 1'b1; end
        12: begin v = 128'ha4970a331a78dc09c418c271e3a41d5d; return 1'b1; end
        default: return 1'b0;
      endcase
      default: case (e)
        0:  begin v = 128'h000102030405060708090a0b0c0d0e0f; return 1'b1; end
        1:  begin v = 128'h101112131415161718191a1b1c1d1e1f; return 1'b1; end
        2:  begin v = 128'ha573c29fa176c498a97fce93a572c09c; return 1'b1; end
        14: begin v = 128'h24fc79ccbf0979e9371ac23c6d68de36; return 1'b1; end
        default: return 1'b0;
      endcase
    endcase
  endfunction

  task automatic rd(input int d, input int r);
    logic [127:0] v;
    bit known;
    sb_t e;
    known = gold(d, eff_of(d, r), v);
    @(negedge clk);
    rr[d] = 4'(r);
    if (known) begin
      e.d = d; e.exp = v; e.nm = $sformatf("rd_key_d%0d_r%0d", d, r);
      pend.push_back(e);
    end
  endtask

  task automatic rd_all(input int d);
    int nr;
    nr = nr_of(d);
    rd(d, 0); rd(d, 1); rd(d, 2); rd(d, nr - 2); rd(d, nr - 1);
    rd(d, nr); rd(d, nr + 1); rd(d, 15);
  endtask

  // Start an expansion and measure start-to-ready latency. With disturb set,
  // a read during expansion, a stray start and a key change are injected.
  task automatic expand(input int d, input logic [255:0] kv, input bit disturb);
    int  cyc;
    bit  done;
    sb_t e;
    @(negedge clk);
    k[d] = kv; st[d] = 1'b1;
    @(posedge clk); #1;
    st[d] = 1'b0;
    chk("busy_after_start", 128'(busy_o[d]), 128'(1));
    chk("ready_after_start", 128'(rdy_o[d]), 128'(0));
    cyc = 0; done = 1'b0;
    while (!done && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (rdy_o[d]) done = 1'b1;
      if (disturb && cyc == 5) begin
        rr[d] = 4'd0;
        e.d = d; e.exp = 128'h0; e.nm = "rd_key_while_busy";
        pend.push_back(e);
      end
      if (disturb && cyc == 10) begin st[d] = 1'b1; k[d] = ~kv; end
      if (disturb && cyc == 11) st[d] = 1'b0;
    end
    chk($sformatf("latency_d%0d", d), 128'(cyc), 128'(g_of(d)));
    chk("busy_at_ready", 128'(busy_o[d]), 128'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1; st[d] = 1'b0; k[d] = '0; rr[d] = 4'd0;
    end
    // Reset wins over a simultaneous start.
    st[2] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("reset_busy", 128'(busy_o[d]), 128'(0));
      chk("reset_ready", 128'(rdy_o[d]), 128'(0));
      chk("reset_rd_key", rdk[d], 128'h0);
      rst[d] = 1'b0;
    end
    st[2] = 1'b0;

    expand(0, K128, 1'b0); rd_all(0);
    expand(1, K192, 1'b0); rd_all(1);
    expand(2, K256, 1'b0); rd_all(2);

    // Restart from DONE with a stray start and a key change mid-expansion.
    expand(2, K256, 1'b1); rd_all(2);

    // Reset 20 cycles into an expansion.
    @(negedge clk);
    st[2] = 1'b1; k[2] = K256;
    @(posedge clk); #1;
    st[2] = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst[2] = 1'b1;
    @(posedge clk); #1;
    chk("midreset_busy", 128'(busy_o[2]), 128'(0));
    chk("midreset_ready", 128'(rdy_o[2]), 128'(0));
    chk("midreset_rd_key", rdk[2], 128'h0);
    rst[2] = 1'b0;

    expand(2, K256, 1'b0); rd_all(2);

    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
